// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared constants and helpers for the DSP48A1-style slice stages.
//   - Operand and OPMODE widths.
//   - OPMODE bit positions that control the B-side pre-adder/subtractor.
//   - preadd_op_e plus decode_preadd(), which turns the two control bits into
//     the pre-adder operation.
// -----------------------------------------------------------------------------
package dsp_pkg;

    localparam int B_W      = 18;
    localparam int D_W      = 18;
    localparam int OPMODE_W = 8;

    // OPMODE bit positions used by the pre-adder.
    localparam int OP_PREADD_EN  = 4;
    localparam int OP_PREADD_SUB = 6;

    typedef enum logic [1:0] {
        PRE_PASS = 2'd0,  // pre = B0
        PRE_ADD  = 2'd1,  // pre = D + B0
        PRE_SUB  = 2'd2   // pre = D - B0
    } preadd_op_e;

    // The subtract bit only matters when the pre-adder is enabled.
    function automatic preadd_op_e decode_preadd(input logic en, input logic sub);
        if (!en)
            return PRE_PASS;
        else if (sub)
            return PRE_SUB;
        else
            return PRE_ADD;
    endfunction

endpackage : dsp_pkg

// File: rtl/reg_bypass.sv
// -----------------------------------------------------------------------------
// reg_bypass
// Optional pipeline register. With ENABLE=1 it is a CE-gated register with an
// asynchronous active-high reset. With ENABLE=0 it is a plain wire, and clk,
// rst and ce are ignored.
//
// Ports:
//   clk  in   1      rising-edge clock
//   rst  in   1      asynchronous active-high reset, clears q
//   ce   in   1      load enable
//   d    in   WIDTH  data in
//   q    out  WIDTH  registered (or bypassed) data out
// -----------------------------------------------------------------------------
module reg_bypass #(
    parameter int WIDTH  = 18,
    parameter bit ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (ENABLE) begin : g_reg
            // NOTE: non-blocking assignments keep every flop sampling pre-edge
            // values, so register ordering never matters.
            // NOTE: reset is asynchronous, so the register clears the moment rst
            // rises instead of waiting for the next clock edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    q <= '0;
                else if (ce)
                    q <= d;
            end
        end else begin : g_wire
            assign q = d;

            // Clock, reset and enable have no role in bypass mode.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, ce};
        end
    endgenerate

endmodule : reg_bypass

// File: rtl/bcout_preadd_stage.sv
// -----------------------------------------------------------------------------
// bcout_preadd_stage
// Drive side of the B cascade. The block aligns D and OPMODE through optional
// registers and then applies the optional D +/- B0 pre-adder. The result goes
// through the optional B1 register to the multiplier (B1_MUX) and to the next
// slice's BCIN (BCOUT).
//
// Ports:
//   CLK       in   1   rising-edge clock
//   RSTB      in   1   asynchronous active-high reset for all registers
//   CEB       in   1   B1 register enable
//   CED       in   1   D register enable
//   CEOPMODE  in   1   OPMODE register enable
//   B0_MUX    in   18  B operand from the B0 stage
//   D         in   18  pre-adder D operand
//   OPMODE    in   8   slice opcode (bit 4 = pre-adder enable, bit 6 = subtract)
//   OPMODE_R  out  8   aligned OPMODE for downstream stages
//   B1_MUX    out  18  pre-adder/B1 result to the multiplier
//   BCOUT     out  18  cascade output, always equal to B1_MUX
// -----------------------------------------------------------------------------
module bcout_preadd_stage
    import dsp_pkg::*;
#(
    parameter bit DREG      = 1'b1,
    parameter bit B1REG     = 1'b1,
    parameter bit OPMODEREG = 1'b1
) (
    input  logic                CLK,
    input  logic                RSTB,
    input  logic                CEB,
    input  logic                CED,
    input  logic                CEOPMODE,
    input  logic [B_W-1:0]      B0_MUX,
    input  logic [D_W-1:0]      D,
    input  logic [OPMODE_W-1:0] OPMODE,
    output logic [OPMODE_W-1:0] OPMODE_R,
    output logic [B_W-1:0]      B1_MUX,
    output logic [B_W-1:0]      BCOUT
);

    logic [D_W-1:0] d_eff;
    logic [B_W-1:0] pre;
    preadd_op_e     pre_op;

    reg_bypass #(.WIDTH(D_W), .ENABLE(DREG)) u_d_reg (
        .clk (CLK),
        .rst (RSTB),
        .ce  (CED),
        .d   (D),
        .q   (d_eff)
    );

    reg_bypass #(.WIDTH(OPMODE_W), .ENABLE(OPMODEREG)) u_opmode_reg (
        .clk (CLK),
        .rst (RSTB),
        .ce  (CEOPMODE),
        .d   (OPMODE),
        .q   (OPMODE_R)
    );

    // The pre-adder uses the aligned OPMODE, so control and D share the same
    // latency.
    assign pre_op = decode_preadd(OPMODE_R[OP_PREADD_EN], OPMODE_R[OP_PREADD_SUB]);

    // D and B are both 18 bits wide. The sum and difference wrap modulo 2^18,
    // and the carry or borrow is dropped.
    always_comb begin
        // NOTE: assigning a default first covers every path through the case,
        // so no latch can be inferred.
        pre = B0_MUX;
        case (pre_op)
            PRE_ADD: pre = d_eff + B0_MUX;
            PRE_SUB: pre = d_eff - B0_MUX;
            default: pre = B0_MUX;
        endcase
    end

    reg_bypass #(.WIDTH(B_W), .ENABLE(B1REG)) u_b1_reg (
        .clk (CLK),
        .rst (RSTB),
        .ce  (CEB),
        .d   (pre),
        .q   (B1_MUX)
    );

    assign BCOUT = B1_MUX;

endmodule : bcout_preadd_stage

// File: tb/tb_bcout_preadd_stage.sv
// -----------------------------------------------------------------------------
// tb_bcout_preadd_stage
// Drives one fully registered instance and one fully bypassed instance from
// shared stimulus. A behavioural model runs alongside them, and literal
// expectations are checked at the key points of the directed sequence.
// -----------------------------------------------------------------------------
module tb_bcout_preadd_stage;

    logic        CLK = 1'b0;
    logic        RSTB;
    logic        CEB, CED, CEOPMODE;
    logic [17:0] B0_MUX, D;
    logic [7:0]  OPMODE;

    logic [7:0]  opmode_r_reg, opmode_r_byp;
    logic [17:0] b1_reg, b1_byp, bcout_reg, bcout_byp;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    always #5 CLK = ~CLK;

    bcout_preadd_stage u_dut_reg (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .CEB      (CEB),
        .CED      (CED),
        .CEOPMODE (CEOPMODE),
        .B0_MUX   (B0_MUX),
        .D        (D),
        .OPMODE   (OPMODE),
        .OPMODE_R (opmode_r_reg),
        .B1_MUX   (b1_reg),
        .BCOUT    (bcout_reg)
    );

    bcout_preadd_stage #(.DREG(1'b0), .B1REG(1'b0), .OPMODEREG(1'b0)) u_dut_byp (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .CEB      (CEB),
        .CED      (CED),
        .CEOPMODE (CEOPMODE),
        .B0_MUX   (B0_MUX),
        .D        (D),
        .OPMODE   (OPMODE),
        .OPMODE_R (opmode_r_byp),
        .B1_MUX   (b1_byp),
        .BCOUT    (bcout_byp)
    );

    // ---------------- behavioural model ----------------
    // Expected pre-adder result, computed as integer arithmetic mod 2^18.
    function automatic logic [17:0] model_pre(input logic [7:0] op, input logic [17:0] dv,
                                              input logic [17:0] bv);
        int unsigned r;
        if (op[4] == 1'b0)
            r = bv;
        else if (op[6] == 1'b1)
            r = (dv + 32'h40000 - bv) % 32'h40000;
        else
            r = (dv + bv) % 32'h40000;
        return r[17:0];
    endfunction

    logic [17:0] m_d, m_b1;
    logic [7:0]  m_op;

    always @(posedge CLK or posedge RSTB) begin
        if (RSTB) begin
            m_d  <= '0;
            m_op <= '0;
            m_b1 <= '0;
        end else begin
            if (CED)      m_d  <= D;
            if (CEOPMODE) m_op <= OPMODE;
            if (CEB)      m_b1 <= model_pre(m_op, m_d, B0_MUX);
        end
    end

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %05h, expected %05h", name, act, exp);
        end
    endtask

    // Compare both instances against the model once per cycle, away from the
    // rising edge.
    always @(negedge CLK) begin
        if (cmp_en) begin
            check("model_b1_reg",    b1_reg,              m_b1);
            check("model_bcout_reg", bcout_reg,           m_b1);
            check("model_op_reg",    {10'd0, opmode_r_reg}, {10'd0, m_op});
            check("model_b1_byp",    b1_byp,              model_pre(OPMODE, D, B0_MUX));
            check("model_bcout_byp", bcout_byp,           model_pre(OPMODE, D, B0_MUX));
            check("model_op_byp",    {10'd0, opmode_r_byp}, {10'd0, OPMODE});
        end
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Literal expectations that pin the model.
    initial begin
        RSTB = 1'b1; CEB = 1'b1; CED = 1'b1; CEOPMODE = 1'b1;
        B0_MUX = '0; D = '0; OPMODE = '0;
        cyc(3);
        check("reset_b1",  b1_reg, 18'h0);
        check("reset_op",  {10'd0, opmode_r_reg}, 18'h0);
        cmp_en = 1'b1;
        RSTB   = 1'b0;

        // Load live data, then assert reset in the middle of a cycle.
        B0_MUX = 18'h00ABC; D = 18'h00010; OPMODE = 8'h10;
        cyc(2);
        check("pre_rst_b1", b1_reg, 18'h00ACC);
        check("pre_rst_op", {10'd0, opmode_r_reg}, 18'h00010);
        #2 RSTB = 1'b1;
        #1;
        check("async_rst_b1",    b1_reg,    18'h0);
        check("async_rst_bcout", bcout_reg, 18'h0);
        check("async_rst_op",    {10'd0, opmode_r_reg}, 18'h0);
        cyc(1);
        RSTB = 1'b0;

        // Pass-through.
        OPMODE = 8'h00; B0_MUX = 18'h12345;
        cyc(1);
        check("pass_b1",    b1_reg,    18'h12345);
        check("pass_bcout", bcout_reg, 18'h12345);

        // Add: D and OPMODE load on the first edge, the sum lands on the second.
        OPMODE = 8'h10; D = 18'h00100; B0_MUX = 18'h00023;
        cyc(2);
        check("add_b1", b1_reg, 18'h00123);

        // Subtract with borrow wrap.
        OPMODE = 8'h50; D = 18'h00001; B0_MUX = 18'h00002;
        cyc(2);
        check("sub_wrap_b1", b1_reg, 18'h3FFFF);

        // Add with carry wrap.
        OPMODE = 8'h10; D = 18'h3FFFF; B0_MUX = 18'h00001;
        cyc(2);
        check("add_wrap_b1", b1_reg, 18'h00000);

        // B1 clock-enable hold.
        OPMODE = 8'h00; B0_MUX = 18'h00555;
        cyc(2);
        check("hold_load_b1", b1_reg, 18'h00555);
        CEB = 1'b0; B0_MUX = 18'h00AAA;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("hold_b1", b1_reg, 18'h00555);
        end
        CEB = 1'b1;
        cyc(1);
        check("release_b1", b1_reg, 18'h00AAA);

        // D and OPMODE enable hold; the model tracks the expected values.
        OPMODE = 8'h10; D = 18'h00040; B0_MUX = 18'h00004;
        cyc(2);
        check("ced_base_b1", b1_reg, 18'h00044);
        CED = 1'b0; CEOPMODE = 1'b0; D = 18'h01000; OPMODE = 8'h50;
        cyc(2);
        check("ced_hold_b1", b1_reg, 18'h00044);
        check("ceop_hold_op", {10'd0, opmode_r_reg}, 18'h00010);
        CED = 1'b1; CEOPMODE = 1'b1;
        cyc(2);
        check("ced_release_b1", b1_reg, 18'h00FFC);

        // Bypass instance: combinational result, unaffected by reset.
        OPMODE = 8'h10; D = 18'h00002; B0_MUX = 18'h00003;
        #1;
        check("byp_add_b1",    b1_byp,    18'h00005);
        check("byp_add_bcout", bcout_byp, 18'h00005);
        check("byp_op",        {10'd0, opmode_r_byp}, 18'h00010);
        RSTB = 1'b1;
        #1;
        check("byp_rst_b1", b1_byp, 18'h00005);
        cyc(1);
        RSTB = 1'b0;

        // Back-to-back stream with every enable set.
        for (int i = 0; i < 8; i++) begin
            OPMODE = (i % 3 == 0) ? 8'h00 : ((i % 3 == 1) ? 8'h10 : 8'h50);
            D      = 18'(i * 18'h01111);
            B0_MUX = 18'(18'h3F000 + i * 18'h00333);
            cyc(1);
        end
        cyc(2);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bcout_preadd_stage
